// File: rtl/hub75_scan_if.sv
// hub75_scan_if: groups the scan scheduler's handshake and panel-control signals.
//   frame_start  frame_manager -> scheduler  one-cycle frame request
//   shift_done   shifter -> scheduler        one-cycle "row/plane shifted in"
//   shift_start  scheduler -> shifter        one-cycle load request
//   shift_row    scheduler -> shifter        requested row
//   shift_plane  scheduler -> shifter        requested bit plane
//   hub75_addr   scheduler -> panel          displayed row address
//   led_latch    scheduler -> panel          latch strobe
//   oe_n         scheduler -> panel          output enable, active low
//   busy         scheduler -> frame_manager  frame in progress
//   frame_done   scheduler -> frame_manager  one-cycle end-of-frame pulse
// ROW_W / PLANE_W must match the scheduler's derived row/plane widths.
interface hub75_scan_if #(
    parameter int unsigned ROW_W   = 5,
    parameter int unsigned PLANE_W = 2
);
    logic               frame_start;
    logic               shift_done;
    logic               shift_start;
    logic [ROW_W-1:0]   shift_row;
    logic [PLANE_W-1:0] shift_plane;
    logic [ROW_W-1:0]   hub75_addr;
    logic               led_latch;
    logic               oe_n;
    logic               busy;
    logic               frame_done;

    // scheduler side
    modport master (
        input  frame_start, shift_done,
        output shift_start, shift_row, shift_plane, hub75_addr,
               led_latch, oe_n, busy, frame_done
    );

    // frame_manager / shifter / panel side
    modport slave (
        output frame_start, shift_done,
        input  shift_start, shift_row, shift_plane, hub75_addr,
               led_latch, oe_n, busy, frame_done
    );
endinterface

// File: rtl/hub75_scan_scheduler.sv
// hub75_scan_scheduler: sequences a HUB75 refresh frame. For every row (outer loop) and
// bit plane (inner loop) it requests a row shift, blanks the panel, latches the shifted
// data and enables the LEDs for BASE_OE_CYCLES<<plane cycles (binary code modulation).
// Ports:
//   clk_in  system clock
//   rst_in  asynchronous active-low reset
//   bus     hub75_scan_if.master (frame_start/shift_done in; shift_start, shift_row,
//           shift_plane, hub75_addr, led_latch, oe_n, busy, frame_done out; all registered)
// Build option: define OVERLAP_SHIFT_EN to issue the next row/plane shift at the start of
// each display period (shifter must double-buffer); otherwise each row/plane is strictly
// shift -> blank -> latch -> display.
module hub75_scan_scheduler #(
    parameter int unsigned SCAN_RATE      = 32,
    parameter int unsigned BIT_PLANES     = 3,
    parameter int unsigned BASE_OE_CYCLES = 16,
    parameter int unsigned BLANK_CYCLES   = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    hub75_scan_if.master bus
);

    localparam int unsigned ROW_W    = (SCAN_RATE > 1) ? $clog2(SCAN_RATE) : 1;
    localparam int unsigned PLANE_W  = (BIT_PLANES > 1) ? $clog2(BIT_PLANES) : 1;
    localparam int unsigned DISP_MAX = BASE_OE_CYCLES << (BIT_PLANES - 1);
    localparam int unsigned CNT_MAX  = (DISP_MAX > BLANK_CYCLES) ? DISP_MAX : BLANK_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(SCAN_RATE - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BIT_PLANES - 1);
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BASE_LEN   = CNT_W'(BASE_OE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY, S_DONE
    } state_t;

    state_t             state_q, next_state;

    logic [ROW_W-1:0]   row_q, row_nxt;
    logic [PLANE_W-1:0] plane_q, plane_nxt;
    logic [ROW_W-1:0]   addr_q, addr_nxt;
    logic [PLANE_W-1:0] disp_plane_q, disp_plane_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               pending_q, pending_nxt;
    logic               shift_start_q, shift_start_nxt;
    logic               latch_q, latch_nxt;
    logic               oe_n_q, oe_n_nxt;
    logic               busy_q, busy_nxt;
    logic               frame_done_q, frame_done_nxt;
`ifdef OVERLAP_SHIFT_EN
    logic               done_seen_q, done_seen_nxt;
`endif

    logic [CNT_W-1:0]   disp_len_c;
    logic               disp_end_c;
    logic               last_unit_c;
    logic               last_issue_c;
    logic               frame_go_c;
    logic [ROW_W-1:0]   adv_row_c;
    logic [PLANE_W-1:0] adv_plane_c;

    // Display length of the plane currently on the panel, and end-of-unit flags.
    always_comb begin
        disp_len_c   = BASE_LEN << disp_plane_q;
        disp_end_c   = (cnt_q == disp_len_c - CNT_W'(1));
        last_unit_c  = (addr_q == ROW_LAST) && (disp_plane_q == PLANE_LAST);
        last_issue_c = (row_q == ROW_LAST) && (plane_q == PLANE_LAST);
        adv_row_c    = row_q;
        adv_plane_c  = plane_q + PLANE_W'(1);
        if (plane_q == PLANE_LAST) begin
            adv_plane_c = '0;
            adv_row_c   = row_q + ROW_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:    if (bus.frame_start || pending_q) next_state = S_SHIFT;
            S_SHIFT:   if (bus.shift_done) next_state = S_BLANK;
            S_BLANK:   if (cnt_q == BLANK_LAST) next_state = S_LATCH;
            S_LATCH:   next_state = S_DISPLAY;
            S_DISPLAY: begin
                if (disp_end_c) begin
                    if (last_unit_c) begin
                        next_state = S_DONE;
                    end else begin
`ifdef OVERLAP_SHIFT_EN
                        // Next unit already shifted during this display: skip SHIFT.
                        next_state = (done_seen_q || bus.shift_done) ? S_BLANK : S_SHIFT;
`else
                        next_state = S_SHIFT;
`endif
                    end
                end
            end
            // A frame_start coinciding with DONE counts as pending: seamless restart.
            S_DONE:    next_state = (pending_q || bus.frame_start) ? S_SHIFT : S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Output / datapath next values, all decoded from the upcoming state.
    always_comb begin
        frame_go_c      = ((state_q == S_IDLE) || (state_q == S_DONE)) && (next_state == S_SHIFT);
        row_nxt         = row_q;
        plane_nxt       = plane_q;
        addr_nxt        = addr_q;
        disp_plane_nxt  = disp_plane_q;
        shift_start_nxt = 1'b0;
        latch_nxt       = (next_state == S_LATCH);
        oe_n_nxt        = (next_state != S_DISPLAY);
        busy_nxt        = (next_state != S_IDLE);
        frame_done_nxt  = (next_state == S_DONE);
        cnt_nxt         = (next_state != state_q) ? '0 : cnt_q + CNT_W'(1);
        pending_nxt     = pending_q;
`ifdef OVERLAP_SHIFT_EN
        done_seen_nxt   = done_seen_q;
`endif

        if (frame_go_c) begin
            pending_nxt = 1'b0;
        end else if (bus.frame_start && (state_q != S_IDLE)) begin
            pending_nxt = 1'b1;
        end

`ifdef OVERLAP_SHIFT_EN
        // Request the next unit as display of the current one begins.
        shift_start_nxt = frame_go_c || ((state_q == S_LATCH) && !last_issue_c);
        if (frame_go_c) begin
            row_nxt   = '0;
            plane_nxt = '0;
        end else if ((state_q == S_LATCH) && !last_issue_c) begin
            row_nxt   = adv_row_c;
            plane_nxt = adv_plane_c;
        end
        if (state_q == S_LATCH) begin
            done_seen_nxt = 1'b0;
        end else if ((state_q == S_DISPLAY) && bus.shift_done) begin
            done_seen_nxt = 1'b1;
        end
`else
        shift_start_nxt = (next_state == S_SHIFT) && (state_q != S_SHIFT);
        if (frame_go_c) begin
            row_nxt   = '0;
            plane_nxt = '0;
        end else if ((state_q == S_DISPLAY) && (next_state == S_SHIFT)) begin
            row_nxt   = adv_row_c;
            plane_nxt = adv_plane_c;
        end
`endif

        // Panel address and display plane follow the unit being latched.
        if (next_state == S_LATCH) begin
            addr_nxt       = row_q;
            disp_plane_nxt = plane_q;
        end
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            row_q         <= '0;
            plane_q       <= '0;
            addr_q        <= '0;
            disp_plane_q  <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            shift_start_q <= 1'b0;
            latch_q       <= 1'b0;
            oe_n_q        <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef OVERLAP_SHIFT_EN
            done_seen_q   <= 1'b0;
`endif
        end else begin
            row_q         <= row_nxt;
            plane_q       <= plane_nxt;
            addr_q        <= addr_nxt;
            disp_plane_q  <= disp_plane_nxt;
            cnt_q         <= cnt_nxt;
            pending_q     <= pending_nxt;
            shift_start_q <= shift_start_nxt;
            latch_q       <= latch_nxt;
            oe_n_q        <= oe_n_nxt;
            busy_q        <= busy_nxt;
            frame_done_q  <= frame_done_nxt;
`ifdef OVERLAP_SHIFT_EN
            done_seen_q   <= done_seen_nxt;
`endif
        end
    end

    assign bus.shift_start = shift_start_q;
    assign bus.shift_row   = row_q;
    assign bus.shift_plane = plane_q;
    assign bus.hub75_addr  = addr_q;
    assign bus.led_latch   = latch_q;
    assign bus.oe_n        = oe_n_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// tb_hub75_scan_scheduler: scoreboard bench for hub75_scan_scheduler (serial build).
// Stimulus pushes the expected per-frame event lists; a monitor pops them as the DUT
// emits shift requests, latches, display runs and frame_done pulses.
module tb_hub75_scan_scheduler;

    localparam int unsigned SCAN_RATE  = 2;
    localparam int unsigned BIT_PLANES = 2;
    localparam int unsigned BASE       = 4;
    localparam int unsigned BLANK      = 2;
    localparam int unsigned LAT        = 3;
    localparam int          UNITS      = SCAN_RATE * BIT_PLANES;
    localparam int          DISP_TOTAL = SCAN_RATE * BASE * ((1 << BIT_PLANES) - 1);
    localparam int          NOMINAL    = UNITS * (LAT + BLANK + 1) + DISP_TOTAL;

    typedef struct {
        int row;
        int plane;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hub75_scan_if #(.ROW_W(1), .PLANE_W(1)) bus ();

    hub75_scan_scheduler #(
        .SCAN_RATE(SCAN_RATE), .BIT_PLANES(BIT_PLANES),
        .BASE_OE_CYCLES(BASE), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    req_t exp_shift[$];
    int   exp_addr[$];
    int   exp_run[$];
    int   exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Reference frame: row outer, plane inner, plane p lit for BASE<<p cycles.
    task automatic push_frame();
        for (int r = 0; r < SCAN_RATE; r++) begin
            for (int p = 0; p < BIT_PLANES; p++) begin
                exp_shift.push_back('{row: r, plane: p});
                exp_addr.push_back(r);
                exp_run.push_back(BASE << p);
            end
        end
        exp_done.push_back(1);
    endtask

    // Shifter model: shift_done LAT cycles after shift_start; optional spurious pulses
    // two and three cycles later (BLANK and LATCH), and forced pulses while idle.
    bit spur_mode = 1'b0;
    bit idle_spur = 1'b0;
    int sd_cnt    = 0;
    int last_real_done = 0;

    initial begin
        bus.shift_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sd_cnt         = 0;
                bus.shift_done = 1'b0;
            end else begin
                bus.shift_done = (sd_cnt == 4) || (spur_mode && (sd_cnt == 2 || sd_cnt == 1))
                                 || idle_spur;
                if (sd_cnt == 4) last_real_done = cyc;
                if (sd_cnt > 0) sd_cnt--;
                if (bus.shift_start) sd_cnt = LAT + 3;
            end
        end
    end

    // Monitor / scoreboard.
    int   run        = 0;
    bit   prev_latch = 1'b0;
    int   frame_t0   = 0;
    req_t mon_e;
    int   mon_v;

    always @(negedge clk) begin
        if (!rst_n) begin
            run        = 0;
            prev_latch = 1'b0;
        end else begin
            if (bus.shift_start) begin
                if (exp_shift.size() == 0) begin
                    check("unexpected_shift_start", 1, 0);
                end else begin
                    mon_e = exp_shift.pop_front();
                    check("shift_row", int'(bus.shift_row), mon_e.row);
                    check("shift_plane", int'(bus.shift_plane), mon_e.plane);
                    if (mon_e.row == 0 && mon_e.plane == 0) frame_t0 = cyc;
                end
                check("busy_at_shift", int'(bus.busy), 1);
            end
            if (bus.led_latch) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_latch", 1, 0);
                end else begin
                    mon_v = exp_addr.pop_front();
                    check("latch_addr", int'(bus.hub75_addr), mon_v);
                end
                check("latch_oe_n", int'(bus.oe_n), 1);
                check("blank_len", cyc - last_real_done, BLANK + 1);
            end
            if (!bus.oe_n) begin
                if (run == 0) check("display_after_latch", int'(prev_latch), 1);
                run++;
            end else if (run > 0) begin
                if (exp_run.size() == 0) begin
                    check("unexpected_oe_run", run, 0);
                end else begin
                    mon_v = exp_run.pop_front();
                    check("oe_run_len", run, mon_v);
                end
                run = 0;
            end
            if (bus.frame_done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    mon_v = exp_done.pop_front();
                    check_range("frame_len", cyc - frame_t0, NOMINAL - UNITS, NOMINAL + UNITS);
                end
                check("done_oe_n", int'(bus.oe_n), 1);
            end
            prev_latch = bus.led_latch;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1'b1;
        end
        if (!seen) check("frame_done_timeout", 0, 1);
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, int'(bus.busy), 0);
            check({tag, "_oe_n"}, int'(bus.oe_n), 1);
            check({tag, "_latch"}, int'(bus.led_latch), 0);
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Quiet after reset.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("rst_oe_n", int'(bus.oe_n), 1);
            check("rst_latch", int'(bus.led_latch), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_addr", int'(bus.hub75_addr), 0);
        end

        // Single frame.
        repeat ($urandom_range(1, 8)) @(negedge clk);
        push_frame();
        pulse_start();
        wait_done(200);
        @(negedge clk);
        check("busy_after_done", int'(bus.busy), 0);
        check("no_restart", int'(bus.shift_start), 0);

        // Spurious shift_done while idle.
        idle_spur = 1'b1;
        repeat (3) @(negedge clk);
        idle_spur = 1'b0;
        check_idle(10, "idle_spur");

        // Spurious shift_done in BLANK and LATCH.
        spur_mode = 1'b1;
        push_frame();
        pulse_start();
        wait_done(200);
        spur_mode = 1'b0;

        // Two requests while busy merge into one extra frame.
        push_frame();
        pulse_start();
        repeat ($urandom_range(5, 15)) @(negedge clk);
        push_frame();
        pulse_start();
        repeat ($urandom_range(3, 10)) @(negedge clk);
        pulse_start();
        wait_done(200);
        @(negedge clk);
        check("busy_between", int'(bus.busy), 1);
        check("seamless_start", int'(bus.shift_start), 1);
        wait_done(200);
        @(negedge clk);
        check("busy_after_pair", int'(bus.busy), 0);

        // frame_start landing on the frame_done cycle.
        repeat (2) @(negedge clk);
        push_frame();
        pulse_start();
        wait_done(200);
        bus.frame_start = 1'b1;
        push_frame();
        @(negedge clk);
        bus.frame_start = 1'b0;
        check("coincident_start", int'(bus.shift_start), 1);
        check("coincident_busy", int'(bus.busy), 1);
        wait_done(200);
        @(negedge clk);
        check("busy_after_coincident", int'(bus.busy), 0);

        // Randomised frames, sometimes with a merged follow-on request.
        for (int k = 0; k < 4; k++) begin
            bit extra;
            extra = 1'($urandom_range(0, 1));
            repeat ($urandom_range(2, 12)) @(negedge clk);
            push_frame();
            pulse_start();
            if (extra) begin
                repeat ($urandom_range(2, 30)) @(negedge clk);
                push_frame();
                pulse_start();
            end
            wait_done(200);
            if (extra) wait_done(200);
            @(negedge clk);
            check("busy_after_rand", int'(bus.busy), 0);
        end

        // Asynchronous reset in the middle of a display period.
        push_frame();
        pulse_start();
        begin
            bit lit = 1'b0;
            for (int i = 0; i < 100 && !lit; i++) begin
                @(negedge clk);
                if (!bus.oe_n) lit = 1'b1;
            end
            if (!lit) check("display_timeout", 0, 1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_oe_n", int'(bus.oe_n), 1);
        check("arst_latch", int'(bus.led_latch), 0);
        check("arst_busy", int'(bus.busy), 0);
        exp_shift.delete();
        exp_addr.delete();
        exp_run.delete();
        exp_done.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle(20, "post_rst");

        check("leftover_shift", exp_shift.size(), 0);
        check("leftover_latch", exp_addr.size(), 0);
        check("leftover_run", exp_run.size(), 0);
        check("leftover_done", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
